cardinal_nic_arb: RTL and testbench
===================================

CARDINAL_NIC_ARB -- requirements
Module: cardinal_nic_arb

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one NIC processor port (2..8).
REQ-002 Parameter LOCK_MAX, 16, max consecutive cycles a lock may be held (>=2).
REQ-003 Port clk  in  1  clock; all state updates on rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port req_valid  in  NUM_REQ  per-requester access request.
REQ-006 Port req_wr  in  NUM_REQ  1=write, 0=read.
REQ-007 Port req_addr  in  2*NUM_REQ  NIC register address, slice i = [2i+1:2i].
REQ-008 Port req_wdata  in  64*NUM_REQ  write data, slice i = [64i+63:64i].
REQ-009 Port req_lock  in  NUM_REQ  request to keep grant after this access.
REQ-010 Port req_gnt  out  NUM_REQ  one-hot grant; access accepted when req_valid[i]&req_gnt[i] at edge.
REQ-011 Port rsp_valid  out  NUM_REQ  one-hot read-response strobe.
REQ-012 Port rsp_data  out  64  read data, qualified by rsp_valid.
REQ-013 Ports nic_addr out 2, nic_d_in out 64, nic_en out 1, nic_en_wr out 1  drive NIC processor port.
REQ-014 Port nic_d_out  in  64  NIC registered read data (valid cycle after nic_en read).

Function
REQ-015 Grant SHALL be combinational, same cycle as request: first asserted req_valid searching from rr_ptr upward, wrapping NUM_REQ-1 -> 0.
REQ-016 req_gnt SHALL be at most one-hot and never asserted for a requester with req_valid low.
REQ-017 nic_en = |req_gnt; nic_addr/nic_d_in/nic_en_wr SHALL mux granted requester's fields; all zero when no grant.
REQ-018 On accepted access by i, rr_ptr SHALL become (i+1) mod NUM_REQ; unchanged when idle.
REQ-019 Accepted read by i SHALL produce rsp_valid[i]=1 exactly one cycle later with rsp_data=nic_d_out; writes produce no response.
REQ-020 rsp_data SHALL be 0 in cycles with no rsp_valid bit set.
REQ-021 Back-to-back accesses every cycle, any requester mix, SHALL be sustained at 1 access/cycle without bubbles.
REQ-022 Arbiter SHALL not filter addresses or retry; write to full output buffer or read of empty input buffer is passed through unchanged.

Reset
REQ-023 On reset: rr_ptr=0, FSM=ARB_OPEN, lock counter=0, rsp_valid=0, rsp_data=0; in-flight read response discarded.
REQ-024 During reset cycles req_gnt=0 and nic_en=0 regardless of req_valid.

Configuration
REQ-025 Macro CARDINAL_NIC_ARB_LOCK_EN SHALL compile in lock support (atomic poll-then-access sequences).
REQ-026 With macro: FSM states ARB_OPEN, ARB_LOCKED; accepted access by i with req_lock[i]=1 -> ARB_LOCKED, owner=i, counter=1.
REQ-027 With macro, in ARB_LOCKED only owner SHALL be granted; others stall; rr_ptr frozen.
REQ-028 With macro, ARB_LOCKED -> ARB_OPEN when owner req_lock low (any cycle) or counter reaches LOCK_MAX; counter increments every locked cycle; on exit rr_ptr=(owner+1) mod NUM_REQ.
REQ-029 Without macro: req_lock ignored, FSM and counter absent, LOCK_MAX unused, pure round-robin.

Structure
REQ-030 Package cardinal_nic_pkg SHALL hold NIC address constants (IN_BUF=00, IN_STATUS=01, OUT_BUF=10, OUT_STATUS=11), NIC_DATA_W=64, arbiter state enum.
REQ-031 Sub-module cardinal_rr_pick SHALL implement the rotate-priority one-hot picker (inputs req vector, ptr; output one-hot).

Verification
REQ-032 Reset, then req_valid=4'b1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3; nic_en=1 every cycle.
REQ-033 Req 2 reads addr 01 while NIC returns 64'h1 -> next cycle rsp_valid=4'b0100, rsp_data=64'h1; all else 0.
REQ-034 Req 1 write addr 10 data 64'hDEAD_BEEF -> nic_en_wr=1, nic_addr=10, nic_d_in=64'hDEAD_BEEF same cycle; no rsp_valid.
REQ-035 Lock build: req 0 reads 01 with lock, req 3 valid -> req 3 stalled until req 0 reads 00 with lock low; next grant = 1 or 3 per ptr=1.
REQ-036 Lock build, LOCK_MAX=4, req 0 holds req_lock forever, req 1 valid -> req 1 granted in 5th cycle after lock entry.
REQ-037 Reset asserted cycle after accepted read -> no rsp_valid emitted; rr_ptr=0 afterward.

Source files
------------

// File: rtl/cardinal_nic_pkg.sv
// Shared NIC register map, data width and arbiter state encoding for the NIC port arbiter.
package cardinal_nic_pkg;

    localparam int unsigned NIC_DATA_W = 64;
    localparam int unsigned NIC_ADDR_W = 2;

    localparam logic [NIC_ADDR_W-1:0] IN_BUF     = 2'b00;
    localparam logic [NIC_ADDR_W-1:0] IN_STATUS  = 2'b01;
    localparam logic [NIC_ADDR_W-1:0] OUT_BUF    = 2'b10;
    localparam logic [NIC_ADDR_W-1:0] OUT_STATUS = 2'b11;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/cardinal_rr_pick.sv
// Rotate-priority picker: one-hot grant to the first set req bit at or above ptr, wrapping.
module cardinal_rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    localparam int unsigned PTR_W = $clog2(N);

    logic [PTR_W-1:0] idx;

    // Walk from lowest to highest priority so the nearest requester at/after ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PTR_W'((32'(ptr) + 32'(k)) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cardinal_nic_arb.sv
// Round-robin arbiter sharing one NIC processor port among NUM_REQ requesters.
// Define CARDINAL_NIC_ARB_LOCK_EN to compile in lock support for atomic access sequences.
module cardinal_nic_arb
    import cardinal_nic_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_wr,
    input  logic [NIC_ADDR_W*NUM_REQ-1:0]    req_addr,
    input  logic [NIC_DATA_W*NUM_REQ-1:0]    req_wdata,
    input  logic [NUM_REQ-1:0]               req_lock,
    output logic [NUM_REQ-1:0]               req_gnt,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [NIC_DATA_W-1:0]            rsp_data,
    output logic [NIC_ADDR_W-1:0]            nic_addr,
    output logic [NIC_DATA_W-1:0]            nic_d_in,
    output logic                             nic_en,
    output logic                             nic_en_wr,
    input  logic [NIC_DATA_W-1:0]            nic_d_out
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_MAX < 2) begin : g_param_err
        $error("cardinal_nic_arb: NUM_REQ must be 2..8 and LOCK_MAX >= 2");
    end

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_ptr_nxt;
    logic [PTR_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [NUM_REQ-1:0] rsp_pend;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    cardinal_rr_pick #(.N(NUM_REQ)) u_pick (
        .req (pick_req),
        .ptr (rr_ptr),
        .gnt (pick_gnt)
    );

    assign req_gnt = reset ? '0 : pick_gnt;
    assign nic_en  = |req_gnt;

    // Route the granted requester's fields onto the NIC port; zero when idle.
    always_comb begin
        gnt_idx   = '0;
        nic_addr  = '0;
        nic_d_in  = '0;
        nic_en_wr = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_gnt[i]) begin
                gnt_idx   = PTR_W'(i);
                nic_addr  = req_addr[NIC_ADDR_W*i +: NIC_ADDR_W];
                nic_d_in  = req_wdata[NIC_DATA_W*i +: NIC_DATA_W];
                nic_en_wr = req_wr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
        end
    end

`ifdef CARDINAL_NIC_ARB_LOCK_EN
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] owner_nxt;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_OPEN;
            owner    <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Lock is released by the owner dropping req_lock or by the hold limit expiring.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        lock_cnt_nxt = lock_cnt;
        rr_ptr_nxt   = rr_ptr;
        case (state)
            ARB_OPEN: begin
                if (nic_en) begin
                    rr_ptr_nxt = ptr_inc(gnt_idx);
                    if (|(req_gnt & req_lock)) begin
                        state_nxt    = ARB_LOCKED;
                        owner_nxt    = gnt_idx;
                        lock_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            ARB_LOCKED: begin
                if (!req_lock[owner] || lock_cnt == CNT_W'(LOCK_MAX)) begin
                    state_nxt    = ARB_OPEN;
                    lock_cnt_nxt = '0;
                    rr_ptr_nxt   = ptr_inc(owner);
                end else begin
                    lock_cnt_nxt = lock_cnt + 1'b1;
                end
            end
            default: state_nxt = ARB_OPEN;
        endcase
    end

    always_comb begin
        pick_req = req_valid;
        if (state == ARB_LOCKED) begin
            pick_req = req_valid & (NUM_REQ'(1) << owner);
        end
    end
`else
    logic unused_lock;

    assign unused_lock = ^req_lock;
    assign pick_req    = req_valid;

    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (nic_en) begin
            rr_ptr_nxt = ptr_inc(gnt_idx);
        end
    end
`endif

    // Read data arrives from the NIC one cycle after the access; a reset drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_pend <= '0;
        end else begin
            rsp_pend <= req_gnt & ~req_wr;
        end
    end

    assign rsp_valid = rsp_pend & {NUM_REQ{~reset}};
    assign rsp_data  = (|rsp_valid) ? nic_d_out : '0;

endmodule

// File: tb/tb_cardinal_nic_arb.sv
// Scoreboard bench for cardinal_nic_arb: directed scenarios then random traffic vs a reference model.
module tb_cardinal_nic_arb;
    import cardinal_nic_pkg::*;

    localparam int unsigned N    = 4;
    localparam int unsigned LMAX = 4;
`ifdef CARDINAL_NIC_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [N-1:0]            req_valid = '0;
    logic [N-1:0]            req_wr = '0;
    logic [2*N-1:0]          req_addr = '0;
    logic [NIC_DATA_W*N-1:0] req_wdata = '0;
    logic [N-1:0]            req_lock = '0;
    logic [N-1:0]            req_gnt;
    logic [N-1:0]            rsp_valid;
    logic [NIC_DATA_W-1:0]   rsp_data;
    logic [1:0]              nic_addr;
    logic [NIC_DATA_W-1:0]   nic_d_in;
    logic                    nic_en;
    logic                    nic_en_wr;
    logic [NIC_DATA_W-1:0]   nic_d_out = '0;

    cardinal_nic_arb #(.NUM_REQ(N), .LOCK_MAX(LMAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_lock  (req_lock),
        .req_gnt   (req_gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .nic_addr  (nic_addr),
        .nic_d_in  (nic_d_in),
        .nic_en    (nic_en),
        .nic_en_wr (nic_en_wr),
        .nic_d_out (nic_d_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          idx;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [63:0] nic_next = '0;

    // Reference model state: pointer, lock flag, owner, cycles held
    int m_ptr = 0;
    bit m_locked = 1'b0;
    int m_owner = 0;
    int m_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [NIC_DATA_W*N-1:0] rand_wd();
        logic [NIC_DATA_W*N-1:0] w;
        for (int i = 0; i < N; i++) w[64*i +: 64] = {$urandom, $urandom};
        return w;
    endfunction

    // One cycle: drive, check the combinational port against the model, queue any read response.
    task automatic step(input bit rst, input logic [N-1:0] v, input logic [N-1:0] wr,
                        input logic [N-1:0] lk, input logic [2*N-1:0] ad,
                        input logic [NIC_DATA_W*N-1:0] wd, input logic [63:0] nd);
        int           g;
        logic [N-1:0] eg;
        logic [1:0]   ea;
        logic [63:0]  edat;
        logic         ewr;
        exp_t         e;
        @(negedge clk);
        cyc++;
        nic_d_out = nic_next;
        nic_next  = nd;
        reset     = rst;
        req_valid = v;
        req_wr    = wr;
        req_lock  = lk;
        req_addr  = ad;
        req_wdata = wd;
        #1;
        if (rst) begin
            while (sb.size() > 0 && sb[0].cyc == cyc) void'(sb.pop_front());
        end
        g = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && v[j] && (!m_locked || j == m_owner)) g = j;
            end
        end
        eg = '0; ea = '0; edat = '0; ewr = 1'b0;
        if (g >= 0) begin
            eg[g] = 1'b1;
            ea    = ad[2*g +: 2];
            edat  = wd[64*g +: 64];
            ewr   = wr[g];
        end
        chk("req_gnt", 64'(req_gnt), 64'(eg));
        chk("nic_en", 64'(nic_en), 64'(g >= 0));
        chk("nic_addr", 64'(nic_addr), 64'(ea));
        chk("nic_d_in", nic_d_in, edat);
        chk("nic_en_wr", 64'(nic_en_wr), 64'(ewr));
        if (g >= 0 && !wr[g]) begin
            e.cyc = cyc + 1; e.idx = g; e.data = nd;
            sb.push_back(e);
        end
        if (rst) begin
            m_ptr = 0; m_locked = 1'b0; m_cnt = 0;
        end else if (m_locked) begin
            if (!lk[m_owner] || m_cnt == LMAX) begin
                m_locked = 1'b0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
            end else begin
                m_cnt++;
            end
        end else if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (LOCK_EN && lk[g]) begin
                m_locked = 1'b1; m_owner = g; m_cnt = 1;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, '0, '0, {$urandom, $urandom});
    endtask

    // Response monitor: pops an expectation whenever one is due, otherwise requires silence.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.idx);
                chk("rsp_data", rsp_data, e.data);
            end else begin
                chk("rsp_valid_idle", 64'(rsp_valid), 64'(0));
                chk("rsp_data_idle", rsp_data, 64'(0));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [2*N-1:0]          ad;
        logic [NIC_DATA_W*N-1:0] wd;
        // Reset with every requester asserting: no grant, no enable
        step(1'b1, '1, '0, '0, '0, '0, 64'h0);
        step(1'b1, '1, '0, '0, '0, '0, 64'h0);
        // Full load of writes: grants rotate 0,1,2,3,0,1,2,3
        for (int i = 0; i < 8; i++) step(1'b0, '1, '1, '0, 8'($urandom), rand_wd(), 64'h0);
        // Requester 2 reads IN_STATUS, NIC returns 1
        ad = '0; ad[5:4] = IN_STATUS;
        step(1'b0, 4'b0100, '0, '0, ad, rand_wd(), 64'h1);
        idle();
        // Requester 1 writes OUT_BUF
        ad = '0; ad[3:2] = OUT_BUF;
        wd = '0; wd[127:64] = 64'hDEAD_BEEF;
        step(1'b0, 4'b0010, 4'b0010, '0, ad, wd, 64'h0);
        idle();
        // Read accepted, then reset in the response cycle drops it
        step(1'b0, 4'b0001, '0, '0, '0, rand_wd(), 64'h1234_5678_9abc_def0);
        step(1'b1, '0, '0, '0, '0, '0, 64'h0);
        step(1'b0, '1, '1, '0, '0, rand_wd(), 64'h0);
`ifdef CARDINAL_NIC_ARB_LOCK_EN
        // Locked poll by requester 0 stalls requester 3 until the lock drops
        step(1'b1, '0, '0, '0, '0, '0, 64'h0);
        ad = '0; ad[1:0] = IN_STATUS;
        step(1'b0, 4'b1001, '0, 4'b0001, ad, rand_wd(), 64'h5);
        step(1'b0, 4'b1001, '0, 4'b0001, ad, rand_wd(), 64'h6);
        step(1'b0, 4'b1001, '0, 4'b0001, ad, rand_wd(), 64'h7);
        ad = '0; ad[1:0] = IN_BUF;
        step(1'b0, 4'b1001, '0, 4'b0000, ad, rand_wd(), 64'h8);
        step(1'b0, 4'b1011, '0, '0, '0, rand_wd(), 64'h9);
        // Lock held forever is cut off after LOCK_MAX cycles
        step(1'b1, '0, '0, '0, '0, '0, 64'h0);
        for (int i = 0; i < 6; i++) step(1'b0, 4'b0011, '0, 4'b0001, '0, rand_wd(), {$urandom, $urandom});
`endif
        // Random traffic with occasional locks and resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 50) == 0, N'($urandom), N'($urandom),
                 N'($urandom) & N'($urandom) & N'($urandom),
                 8'($urandom), rand_wd(), {$urandom, $urandom});
        end
        idle();
        idle();
        chk("sb_drain", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
